pl_spi_slave_9910: RTL and testbench

SPI target (responder) that models the AD9910 serial port, the far end of the DDS SPI master. It oversamples SCLK, CS and MOSI in the `i_Clk` domain and decodes instruction-byte + data-byte frames. It holds a 22-entry register image with DDS-defined widths, answers read frames on MISO and reports every committed write. It serves as a bench/loopback target and as a register shadow for on-chip monitoring.

---
 rtl/pl_spi_9910_pkg.sv | 57 +++++
 rtl/pl_spi_sync_edge.sv | 33 +++
 rtl/pl_spi_slave_9910.sv | 192 +++++++++++++++++++
 tb/tb_pl_spi_slave_9910.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_spi_9910_pkg.sv
// pl_spi_9910_pkg: shared constants and helpers for the AD9910 SPI target.
// Register map widths, reset image and instruction-byte layout.
package pl_spi_9910_pkg;

    localparam int N_REGS = 22;

    localparam logic [4:0] ADDR_CFR1 = 5'h00;
    localparam logic [4:0] ADDR_CFR2 = 5'h01;
    localparam logic [4:0] ADDR_CFR3 = 5'h02;
    localparam logic [4:0] ADDR_DAC  = 5'h03;
    localparam logic [4:0] ADDR_IOUR = 5'h04;
    localparam logic [4:0] ADDR_FTW  = 5'h07;
    localparam logic [4:0] ADDR_POW  = 5'h08;
    localparam logic [4:0] ADDR_LAST = 5'h15;

    localparam logic [63:0] RST_CFR2 = 64'h0000_0000_0040_0820;
    localparam logic [63:0] RST_CFR3 = 64'h0000_0000_1738_4000;
    localparam logic [63:0] RST_DAC  = 64'h0000_0000_0000_007F;
    localparam logic [63:0] RST_IOUR = 64'h0000_0000_FFFF_FFFF;

    localparam int INSTR_RW_BIT   = 7;
    localparam int INSTR_ADDR_MSB = 4;

    localparam logic [3:0] BYTE_SAT = 4'd9;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_INSTR,
        ST_DATA
    } state_t;

    // Register length in bytes; 0 marks an address with no register
    function automatic logic [3:0] reg_len(input logic [4:0] addr);
        case (addr)
            5'h08:                      return 4'd2;
            5'h00, 5'h01, 5'h02, 5'h03,
            5'h04, 5'h07, 5'h09, 5'h0A,
            5'h0D:                      return 4'd4;
            5'h0B, 5'h0C, 5'h0E, 5'h0F,
            5'h10, 5'h11, 5'h12, 5'h13,
            5'h14, 5'h15:               return 4'd8;
            default:                    return 4'd0;
        endcase
    endfunction

    function automatic logic [63:0] rst_val(input logic [4:0] addr);
        case (addr)
            ADDR_CFR2: return RST_CFR2;
            ADDR_CFR3: return RST_CFR3;
            ADDR_DAC:  return RST_DAC;
            ADDR_IOUR: return RST_IOUR;
            default:   return 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/pl_spi_sync_edge.sv
// pl_spi_sync_edge: 2-FF synchronizer for an asynchronous pin,
// followed by a one-cycle rise/fall detector on the synchronized level.
module pl_spi_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-stage synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/pl_spi_slave_9910.sv
// pl_spi_slave_9910: oversampled SPI target mirroring the AD9910 port.
// Decodes instruction + data frames into a 22-entry register image.
module pl_spi_slave_9910
    import pl_spi_9910_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_SPI_Clk,
    input  logic        i_SPI_CS,
    input  logic        i_SPI_MOSI,
    output logic        o_SPI_MISO,
    output logic        o_Wr_Valid,
    output logic [4:0]  o_Wr_Addr,
    output logic [63:0] o_Wr_Data,
    input  logic [4:0]  i_Rd_Addr,
    output logic [63:0] o_Rd_Data,
    output logic        o_Busy,
    output logic        o_Err
);

    logic sck_rise, sck_fall, sck_lvl_unused;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi, mosi_rise_unused, mosi_fall_unused;

    pl_spi_sync_edge u_sck (
        .clk_i(i_Clk), .rst_i(i_Rst), .pin_i(i_SPI_Clk),
        .level_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    pl_spi_sync_edge u_cs (
        .clk_i(i_Clk), .rst_i(i_Rst), .pin_i(i_SPI_CS),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    pl_spi_sync_edge u_mosi (
        .clk_i(i_Clk), .rst_i(i_Rst), .pin_i(i_SPI_MOSI),
        .level_o(mosi), .rise_o(mosi_rise_unused),
        .fall_o(mosi_fall_unused)
    );

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [63:0] shift_q, shift_d;
    logic [63:0] miso_sh_q, miso_sh_d;
    logic        miso_q, miso_d;
    logic        rd_q, rd_d;
    logic [4:0]  addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic        wr_valid_q;
    logic [4:0]  wr_addr_q;
    logic [63:0] wr_data_q;
    logic        err_q, err_d;
    logic        commit;

    logic [63:0] regs_q [N_REGS];

    // The 8th instruction bit arrives with the latching edge itself
    logic [4:0]  instr_addr;
    logic [3:0]  instr_len;
    logic [6:0]  instr_shamt;
    logic [63:0] instr_img;

    assign instr_addr  = {shift_q[INSTR_ADDR_MSB-1:0], mosi};
    assign instr_len   = reg_len(instr_addr);
    assign instr_shamt = 7'd64 - {instr_len, 3'b000};
    assign instr_img   = (instr_len == 4'd0) ? 64'd0
                       : (regs_q[instr_addr] << instr_shamt);

    // Frame sequencing; a CS rise always wins over a same-cycle SCLK edge
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        miso_sh_d  = miso_sh_q;
        miso_d     = miso_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        len_d      = len_q;
        err_d      = 1'b0;
        commit     = 1'b0;
        unique case (state_q)
            ST_SYNC: begin
                if (cs_lvl) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_INSTR;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 4'd0;
                    shift_d    = 64'd0;
                end
            end
            ST_INSTR: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (sck_rise) begin
                    shift_d   = {shift_q[62:0], mosi};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rd_d      = shift_q[INSTR_RW_BIT-1];
                        addr_d    = instr_addr;
                        len_d     = instr_len;
                        shift_d   = 64'd0;
                        miso_sh_d = instr_img;
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                    if (rd_q) begin
                        err_d = (len_q == 4'd0) || (bit_cnt_q != 3'd0);
                    end else if (len_q != 4'd0 && bit_cnt_q == 3'd0
                                 && byte_cnt_q == len_q) begin
                        commit = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7 && byte_cnt_q != BYTE_SAT)
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    if (!rd_q) shift_d = {shift_q[62:0], mosi};
                end else if (sck_fall && rd_q) begin
                    miso_d    = miso_sh_q[63];
                    miso_sh_d = {miso_sh_q[62:0], 1'b0};
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= ST_SYNC;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 4'd0;
            shift_q    <= 64'd0;
            miso_sh_q  <= 64'd0;
            miso_q     <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= 5'd0;
            len_q      <= 4'd0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= 64'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            miso_sh_q  <= miso_sh_d;
            miso_q     <= miso_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wr_valid_q <= commit;
            err_q      <= err_d;
            if (commit) begin
                wr_addr_q <= addr_q;
                wr_data_q <= shift_q;
            end
        end
    end

    // Register image: DDS defaults on reset, updated only by a commit
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int i = 0; i < N_REGS; i++)
                regs_q[i] <= rst_val(5'(i));
        end else if (commit) begin
            regs_q[addr_q] <= shift_q;
        end
    end

    assign o_Rd_Data  = (reg_len(i_Rd_Addr) != 4'd0) ? regs_q[i_Rd_Addr]
                                                     : 64'd0;
    assign o_SPI_MISO = miso_q;
    assign o_Wr_Valid = wr_valid_q;
    assign o_Wr_Addr  = wr_addr_q;
    assign o_Wr_Data  = wr_data_q;
    assign o_Err      = err_q;
    assign o_Busy     = (state_q == ST_INSTR) || (state_q == ST_DATA);

endmodule

// File: tb/tb_pl_spi_slave_9910.sv
// tb_pl_spi_slave_9910: directed + random SPI frames against a
// byte-level register-map model of the AD9910 serial port.
module tb_pl_spi_slave_9910;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        cs;
    logic        mosi;
    logic        miso;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    pl_spi_slave_9910 dut (
        .i_Clk(clk), .i_Rst(rst), .i_SPI_Clk(sck), .i_SPI_CS(cs),
        .i_SPI_MOSI(mosi), .o_SPI_MISO(miso), .o_Wr_Valid(wr_valid),
        .o_Wr_Addr(wr_addr), .o_Wr_Data(wr_data), .i_Rd_Addr(rd_addr),
        .o_Rd_Data(rd_data), .o_Busy(busy), .o_Err(err)
    );

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;
    logic [68:0] wr_log[$];
    logic [63:0] model[32];
    logic [7:0]  txb[16];
    logic [7:0]  rxb[16];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte lengths from the AD9910 register map
    function automatic int spec_len(input int a);
        if (a == 8) return 2;
        if (a <= 4 || a == 7 || a == 9 || a == 10 || a == 13) return 4;
        if (a == 11 || a == 12 || (a >= 14 && a <= 21)) return 8;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        model[1] = 64'h0040_0820;
        model[2] = 64'h1738_4000;
        model[3] = 64'h0000_007F;
        model[4] = 64'hFFFF_FFFF;
    endtask

    always @(negedge clk) begin
        if (wr_valid) wr_log.push_back({wr_addr, wr_data});
        if (err) err_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCLK period; MISO sampled just before the rising pin edge
    task automatic sbit(input logic b, output logic s);
        mosi = b;
        tick(5);
        s = miso;
        sck = 1'b1;
        tick(5);
        sck = 1'b0;
    endtask

    task automatic frame(input int nbytes, input int xbits, input int gap);
        logic s;
        cs = 1'b0;
        tick(5);
        for (int i = 0; i < nbytes; i++)
            for (int j = 7; j >= 0; j--) begin
                sbit(txb[i][j], s);
                rxb[i][j] = s;
            end
        for (int k = 0; k < xbits; k++) sbit(1'($urandom), s);
        tick(5);
        cs = 1'b1;
        tick(gap);
    endtask

    task automatic chk_img(input int a);
        rd_addr = 5'(a);
        #1;
        chk($sformatf("img@%02h", a), rd_data, model[a]);
    endtask

    // Runs a frame and checks commit/err/MISO against the register map
    task automatic do_frame(input string tag, input int nbytes,
                            input int xbits);
        int w0, e0, a, len, nd, k;
        bit rdf, ok, exp_err, exp_wr;
        logic [63:0] v;
        w0 = wr_log.size();
        e0 = err_seen;
        frame(nbytes, xbits, 8);
        exp_wr = 1'b0;
        if (nbytes == 0) begin
            exp_err = 1'b1;
        end else begin
            rdf = txb[0][7];
            a   = int'(txb[0][4:0]);
            len = spec_len(a);
            nd  = nbytes - 1;
            chk({tag, "_miso_instr"}, 64'(rxb[0]), 64'd0);
            if (rdf) begin
                exp_err = (len == 0) || (xbits != 0);
                for (int i = 1; i < nbytes; i++) begin
                    k = i - 1;
                    v = (k < len) ? ((model[a] >> (8 * (len - 1 - k)))
                                     & 64'hFF) : 64'd0;
                    chk($sformatf("%s_miso%0d", tag, k), 64'(rxb[i]), v);
                end
            end else begin
                ok = (len != 0) && (xbits == 0) && (nd == len);
                exp_err = !ok;
                if (ok) begin
                    v = 64'd0;
                    for (int i = 1; i < nbytes; i++)
                        v = (v << 8) | 64'(txb[i]);
                    model[a] = v;
                    exp_wr = 1'b1;
                    if (wr_log.size() > w0) begin
                        chk({tag, "_waddr"}, 64'(wr_log[$][68:64]),
                            64'(a));
                        chk({tag, "_wdata"}, wr_log[$][63:0], v);
                    end
                end
            end
        end
        chk({tag, "_nwr"}, 64'(wr_log.size() - w0), 64'(exp_wr));
        chk({tag, "_nerr"}, 64'(err_seen - e0), 64'(exp_err));
    endtask

    initial begin
        int w0, e0, a, nd, len, xb, nb;
        logic s;
        rst = 1'b1; sck = 1'b0; cs = 1'b1; mosi = 1'b0; rd_addr = 5'd1;
        model_reset();
        tick(6);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_miso", 64'(miso), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        for (int i = 0; i < 24; i++) chk_img(i);
        rst = 1'b0;
        tick(8);

        txb[0] = 8'h07; txb[1] = 8'h12; txb[2] = 8'h34;
        txb[3] = 8'h56; txb[4] = 8'h78;
        do_frame("ftw", 5, 0);
        chk_img(7);

        txb[0] = 8'h08; txb[1] = 8'hAB; txb[2] = 8'hCD;
        do_frame("pow_wr", 3, 0);
        txb[0] = 8'h88; txb[1] = 8'h00; txb[2] = 8'h00;
        do_frame("pow_rd", 3, 0);

        txb[0] = 8'h0B;
        for (int i = 1; i < 6; i++) txb[i] = 8'(i * 17);
        do_frame("short", 6, 0);
        chk_img(11);

        txb[0] = 8'h05;
        for (int i = 1; i < 5; i++) txb[i] = 8'hA5;
        do_frame("inv_wr", 5, 0);
        txb[0] = 8'h85;
        do_frame("inv_rd", 5, 0);

        txb[0] = 8'h87; txb[1] = 8'h00; txb[2] = 8'h00;
        do_frame("rd_part", 3, 3);
        txb[0] = 8'h07; txb[1] = 8'h11; txb[2] = 8'h22;
        do_frame("wr_part", 3, 5);

        e0 = err_seen;
        cs = 1'b0;
        tick(5);
        chk("busy_frame", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) sbit(1'b1, s);
        tick(5);
        cs = 1'b1;
        tick(8);
        chk("abort_err", 64'(err_seen - e0), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);

        txb[0] = 8'h01; txb[1] = 8'hFF; txb[2] = 8'h00;
        w0 = wr_log.size();
        e0 = err_seen;
        cs = 1'b0;
        tick(5);
        for (int i = 0; i < 12; i++) sbit(txb[i / 8][7 - (i % 8)], s);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) sbit(1'($urandom), s);
        tick(5);
        cs = 1'b1;
        tick(8);
        chk("mrst_nwr", 64'(wr_log.size() - w0), 64'd0);
        chk("mrst_nerr", 64'(err_seen - e0), 64'd0);
        chk_img(1);
        chk_img(7);
        txb[0] = 8'h01; txb[1] = 8'hCA; txb[2] = 8'hFE;
        txb[3] = 8'hBA; txb[4] = 8'hBE;
        do_frame("post_rst", 5, 0);
        chk_img(1);

        w0 = wr_log.size();
        txb[0] = 8'h0E;
        for (int i = 1; i < 9; i++) txb[i] = 8'(i);
        frame(9, 0, 4);
        txb[0] = 8'h0D; txb[1] = 8'hDE; txb[2] = 8'hAD;
        txb[3] = 8'hBE; txb[4] = 8'hEF;
        frame(5, 0, 8);
        model[14] = 64'h0102_0304_0506_0708;
        model[13] = 64'hDEAD_BEEF;
        chk("b2b_nwr", 64'(wr_log.size() - w0), 64'd2);
        if (wr_log.size() >= w0 + 2) begin
            chk("b2b_d0", wr_log[w0][63:0], 64'h0102_0304_0506_0708);
            chk("b2b_a0", 64'(wr_log[w0][68:64]), 64'h0E);
            chk("b2b_d1", wr_log[w0 + 1][63:0], 64'hDEAD_BEEF);
            chk("b2b_a1", 64'(wr_log[w0 + 1][68:64]), 64'h0D);
        end
        chk_img(13);
        chk_img(14);

        for (int n = 0; n < 40; n++) begin
            a   = $urandom_range(0, 31);
            len = spec_len(a);
            case ($urandom_range(0, 3))
                0, 1:    nd = (len == 0) ? 4 : len;
                2:       nd = $urandom_range(0, 9);
                default: nd = (len == 0) ? 2 : len + $urandom_range(0, 2) - 1;
            endcase
            xb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
            nb = ($urandom_range(0, 14) == 0) ? 0 : nd + 1;
            txb[0] = {1'($urandom), 2'($urandom), 5'(a)};
            for (int i = 1; i < 16; i++) txb[i] = 8'($urandom);
            do_frame($sformatf("rnd%0d", n), nb, (nb == 0) ? xb : xb);
            chk_img($urandom_range(0, 31));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
